// File: rtl/mod_n_counter.sv
// Free-running modulo-NUM up-counter with a terminal-count decode.
// Provides the phase count for clock dividers and other periodic timing blocks.
module mod_n_counter #(
   parameter int NUM = 4
) (
   input  logic                   clk_sig,
   input  logic                   reset_sig,
   output logic [$clog2(NUM)-1:0] counter_sig,
   output logic                   wrap_sig
);

   localparam int W = $clog2(NUM);
   localparam logic [W-1:0] LAST = W'(NUM - 1);

   generate
      if (NUM < 2) begin : g_bad_num
         $error("mod_n_counter: NUM must be >= 2 (got %0d)", NUM);
      end
   endgenerate

   // The power-up value keeps the count defined when reset is tied inactive.
   logic [W-1:0] count = '0;

   // A count at or beyond NUM-1 loads zero, so a corrupted state also recovers.
   always_ff @(posedge clk_sig or negedge reset_sig) begin
      if (!reset_sig) begin
         count <= '0;
      end else if (count >= LAST) begin
         count <= '0;
      end else begin
         count <= count + W'(1);
      end
   end

   assign counter_sig = count;
   assign wrap_sig    = (count == LAST);

endmodule

// File: tb/tb_mod_n_counter.sv
// Directed self-checking bench for mod_n_counter at NUM = 2, 4, 5 and 8.
// This includes an instance whose reset is tied high.
module tb_mod_n_counter;

   logic clk = 1'b0;
   logic rst4 = 1'b0;
   logic rst5 = 1'b0;
   logic rst8 = 1'b0;
   logic rst2 = 1'b0;

   logic [1:0] cnt_tie;
   logic       wrap_tie;
   logic [1:0] cnt4;
   logic       wrap4;
   logic [2:0] cnt5;
   logic       wrap5;
   logic [2:0] cnt8;
   logic       wrap8;
   logic [0:0] cnt2;
   logic       wrap2;

   int checks = 0;
   int passed = 0;

   always #5 clk = ~clk;

   mod_n_counter #(.NUM(4)) u_tie (.clk_sig(clk), .reset_sig(1'b1), .counter_sig(cnt_tie), .wrap_sig(wrap_tie));
   mod_n_counter #(.NUM(4)) u4    (.clk_sig(clk), .reset_sig(rst4), .counter_sig(cnt4),    .wrap_sig(wrap4));
   mod_n_counter #(.NUM(5)) u5    (.clk_sig(clk), .reset_sig(rst5), .counter_sig(cnt5),    .wrap_sig(wrap5));
   mod_n_counter #(.NUM(8)) u8    (.clk_sig(clk), .reset_sig(rst8), .counter_sig(cnt8),    .wrap_sig(wrap8));
   mod_n_counter #(.NUM(2)) u2    (.clk_sig(clk), .reset_sig(rst2), .counter_sig(cnt2),    .wrap_sig(wrap2));

   task automatic test_tied_reset();
      #1;
      checks++;
      if (cnt_tie !== 2'd0) $display("[TB] FAIL tie_t0: got %b expected 00", cnt_tie);
      else passed++;
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         checks++;
         if (cnt_tie !== 2'(i % 4)) $display("[TB] FAIL tie_seq[%0d]: got %b expected %0d", i, cnt_tie, i % 4);
         else passed++;
         checks++;
         if (wrap_tie !== ((i % 4) == 3)) $display("[TB] FAIL tie_wrap[%0d]: got %b expected %0d", i, wrap_tie, (i % 4) == 3);
         else passed++;
      end
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (cnt4 !== 2'd0 || wrap4 !== 1'b0) $display("[TB] FAIL reset_hold[%0d]: got cnt=%b wrap=%b expected cnt=00 wrap=0", i, cnt4, wrap4);
         else passed++;
      end
      rst4 = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         checks++;
         if (cnt4 !== 2'(i % 4)) $display("[TB] FAIL release_seq[%0d]: got %b expected %0d", i, cnt4, i % 4);
         else passed++;
         checks++;
         if (wrap4 !== ((i % 4) == 3)) $display("[TB] FAIL release_wrap[%0d]: got %b expected %0d", i, wrap4, (i % 4) == 3);
         else passed++;
      end
   endtask

   task automatic test_mid_reset();
      @(negedge clk);
      checks++;
      if (cnt4 !== 2'd2) $display("[TB] FAIL mid_pre: got %b expected 10", cnt4);
      else passed++;
      #2 rst4 = 1'b0;
      #1;
      checks++;
      if (cnt4 !== 2'd0) $display("[TB] FAIL mid_async: got %b expected 00", cnt4);
      else passed++;
      @(negedge clk);
      checks++;
      if (cnt4 !== 2'd0 || wrap4 !== 1'b0) $display("[TB] FAIL mid_hold: got cnt=%b wrap=%b expected cnt=00 wrap=0", cnt4, wrap4);
      else passed++;
      rst4 = 1'b1;
      for (int i = 1; i <= 2; i++) begin
         @(negedge clk);
         checks++;
         if (cnt4 !== 2'(i)) $display("[TB] FAIL mid_restart[%0d]: got %b expected %0d", i, cnt4, i);
         else passed++;
      end
   endtask

   task automatic test_mod5();
      checks++;
      if (cnt5 !== 3'd0) $display("[TB] FAIL mod5_reset: got %b expected 000", cnt5);
      else passed++;
      rst5 = 1'b1;
      for (int i = 1; i <= 11; i++) begin
         @(negedge clk);
         checks++;
         if (cnt5 !== 3'(i % 5)) $display("[TB] FAIL mod5_seq[%0d]: got %0d expected %0d", i, cnt5, i % 5);
         else passed++;
         checks++;
         if (wrap5 !== ((i % 5) == 4)) $display("[TB] FAIL mod5_wrap[%0d]: got %b expected %0d", i, wrap5, (i % 5) == 4);
         else passed++;
      end
   endtask

   // A divider formed as count < 4 should be high for half of each 8-cycle period.
   task automatic test_mod8_divider();
      int wraps = 0;
      int highs = 0;
      rst8 = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         @(negedge clk);
         checks++;
         if (cnt8 !== 3'(i % 8)) $display("[TB] FAIL mod8_seq[%0d]: got %0d expected %0d", i, cnt8, i % 8);
         else passed++;
         if (wrap8 === 1'b1) wraps++;
         if (cnt8 < 3'd4) highs++;
      end
      checks++;
      if (wraps != 2) $display("[TB] FAIL mod8_wrap_count: got %0d expected 2", wraps);
      else passed++;
      checks++;
      if (highs != 8) $display("[TB] FAIL mod8_duty: got %0d expected 8", highs);
      else passed++;
   endtask

   task automatic test_mod2();
      rst2 = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         checks++;
         if (cnt2 !== 1'(i % 2)) $display("[TB] FAIL mod2_seq[%0d]: got %b expected %0d", i, cnt2, i % 2);
         else passed++;
         checks++;
         if (wrap2 !== 1'(i % 2)) $display("[TB] FAIL mod2_wrap[%0d]: got %b expected %0d", i, wrap2, i % 2);
         else passed++;
      end
   endtask

   initial begin
      test_tied_reset();
      test_reset();
      test_mid_reset();
      test_mod5();
      test_mod8_divider();
      test_mod2();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
